mul_pipe_hs: RTL
================

# mul_pipe_hs

Parametrised, pipelined N×N multiplier with a valid/ready handshake on both sides and per-transaction signed/unsigned mode. It succeeds the fixed 32-bit, enable-gated registered multiplier: width and pipeline depth are generic, backpressure replaces the global enable, and result ordering is defined rather than half-swapped. It sits between an operand producer (ALU issue or DSP front end) and a result consumer that may stall.

## Interface
- N, 32, operand width in bits (≥2).
- STAGES, 2, pipeline register stages (2..6). Stage 1 holds operands; stages 2..STAGES hold the product.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  **synchronous, active-high**; sampled on the rising edge of clk.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept; combinational: in_ready = advance.
- a  in  N  multiplicand.
- b  in  N  multiplier.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with a, b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  2N  full product, {high half, low half}, not truncated.

## Operation
- advance = !out_valid || out_ready. A global stall freezes the whole pipeline together. There is no bubble collapsing.
- Acceptance happens when in_valid && in_ready at a rising edge. On that edge stage 1 captures a, b, is_signed and sets v1 = 1.
- On each advance edge:
  - v1 ← in_valid.
  - v[k] ← v[k-1] for k = 2..STAGES.
  - A data register loads only when its incoming valid is 1. Otherwise it holds, so result keeps its last value across bubbles.
- Product is formed from stage 1:
  - Each operand is extended to N+1 bits: sign-extended if is_signed, else zero-extended.
  - The operands are multiplied and the low 2N bits are kept. This is exact for both modes.
  - The product is registered into stage 2. Stages 3..STAGES are plain delay registers.
- out_valid = v[STAGES]; result = data of stage STAGES.
- Transactions leave in acceptance order. No transaction is dropped or duplicated.
- While out_valid && !out_ready, result and out_valid stay stable, and in_ready = 0.

## Timing
- Reset, effective on the edge where reset = 1:
  - All v[k] = 0 and all data registers = 0.
  - out_valid = 0 and result = 0.
  - in_ready = 1 from the following cycle.
  - reset wins over advance and acceptance on the same edge. In-flight transactions are discarded without being output.
- Latency: a transaction accepted at edge k is presented (out_valid = 1) after edge k+STAGES−1. The default (STAGES = 2) presents it in the cycle after the edge following acceptance.
- Throughput is 1 transaction/cycle while out_ready = 1.
- Simultaneous events:
  - out_valid && out_ready && in_valid in the same cycle: the output retires and a new operand enters on the same edge.
  - When the pipeline is full and out_ready = 0, in_ready = 0 and inputs are ignored.
- in_ready depends combinationally on out_ready. The upstream must not make in_valid depend on in_ready.

## Structure
- Package mul_pkg holds:
  - MUL_MIN_STAGES = 2 and MUL_MAX_STAGES = 6.
  - A function mul_ext(op, is_signed, N) returning the N+1-bit extended operand.
- Elaborate-time check: fail if STAGES is outside 2..6 or N < 2.
- One sub-module, mul_stage_reg #(W): W-bit data plus valid, with synchronous active-high reset, load-on-advance and data-gated-by-valid. It is instantiated once per stage and generalises the plain N-bit register.

## Test plan
- Unsigned, N=32, STAGES=2: a=0xFFFFFFFF, b=0xFFFFFFFF, out_ready=1 → result=0xFFFFFFFE00000001, out_valid exactly 2 cycles after acceptance.
- Signed, N=32: (a=0xFFFFFFFF, b=0xFFFFFFFF) → 0x0000000000000001; (0x80000000, 0x80000000) → 0x4000000000000000; (0x80000000, 0x00000001) → 0xFFFFFFFF80000000.
- Back-to-back with STAGES=4: stream 10 operand pairs, with is_signed alternating per transaction → 10 results in order, one per cycle, first after 4 edges, each matching the reference model.
- Backpressure: hold out_ready=0 with the pipe full → in_ready=0, result/out_valid stable for 5 cycles. Release → drain in order, no loss or duplication.
- Reset mid-operation: 3 transactions in flight, assert reset for 1 cycle → out_valid=0, result=0 next cycle, no stale result ever emitted. The next accepted 7×6 → 42.
- Bubbles: in_valid toggling 1,0,1 → out_valid pattern 1,0,1 delayed by STAGES−1. result holds the first product during the bubble.

Source files
------------

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared constants and operand-extension helper for the
//                pipelined handshake multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

  localparam int MUL_MIN_STAGES = 2;
  localparam int MUL_MAX_STAGES = 6;

  // Working width of the extension helper; bounds the largest supported N.
  localparam int MUL_EXT_W = 257;
  localparam int MUL_MAX_N = MUL_EXT_W - 1;

  // Extend the low n bits of op to n+1 bits (and beyond, up to MUL_EXT_W):
  // sign-extended when is_signed, zero-extended otherwise.
  function automatic logic [MUL_EXT_W-1:0] mul_ext(
    input logic [MUL_EXT_W-1:0] op,
    input logic                 is_signed,
    input int unsigned          n
  );
    logic [MUL_EXT_W-1:0] mask;
    logic                 fill;
    mask = ~({MUL_EXT_W{1'b1}} << n);
    fill = is_signed && (((op >> (n - 1)) & MUL_EXT_W'(1)) != '0);
    return (op & mask) | (fill ? ~mask : '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_stage_reg
//  Description : One pipeline stage: W-bit data plus valid. Moves only on
//                advance; data loads only when the incoming valid is set so
//                the last value is held across bubbles.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         advance,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  // Valid follows upstream on every advance; data is gated by that valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (advance) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_pipe_hs.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pipe_hs
//  Description : Parametrised N x N pipelined multiplier with valid/ready on
//                both sides and per-transaction signed/unsigned mode. Stage 1
//                holds operands, stage 2 the product, stages 3..STAGES delay.
//                A single global stall freezes every stage together.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_pipe_hs
  import mul_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] result
);

  // Reject unsupported configurations at elaboration.
  generate
    if (STAGES < MUL_MIN_STAGES || STAGES > MUL_MAX_STAGES || N < 2 || N > MUL_MAX_N) begin : g_bad_params
      $error("mul_pipe_hs: unsupported N=%0d / STAGES=%0d", N, STAGES);
    end
  endgenerate

  logic           advance;
  logic           v [1:STAGES];
  logic [2*N:0]   s1_data;
  logic [2*N-1:0] d [2:STAGES];

  logic           s1_signed;
  logic [N-1:0]   s1_a;
  logic [N-1:0]   s1_b;
  logic [N:0]     ext_a;
  logic [N:0]     ext_b;
  logic [2*N-1:0] wide_a;
  logic [2*N-1:0] wide_b;
  logic [2*N-1:0] prod;

  // The output slot frees up when empty or being consumed; everything moves together.
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = v[STAGES];
  assign result    = d[STAGES];

  // Stage 1: operand capture.
  mul_stage_reg #(.W(2*N+1)) u_stage1 (
    .clk       (clk),
    .reset     (reset),
    .advance   (advance),
    .in_valid  (in_valid),
    .in_data   ({is_signed, a, b}),
    .out_valid (v[1]),
    .out_data  (s1_data)
  );

  assign {s1_signed, s1_a, s1_b} = s1_data;

  // N+1-bit extension makes one signed multiply exact for both modes; widening
  // further to 2N and keeping the low 2N bits of the product is equivalent.
  assign ext_a  = (N+1)'(mul_ext(MUL_EXT_W'(s1_a), s1_signed, N));
  assign ext_b  = (N+1)'(mul_ext(MUL_EXT_W'(s1_b), s1_signed, N));
  assign wide_a = {{(N-1){ext_a[N]}}, ext_a};
  assign wide_b = {{(N-1){ext_b[N]}}, ext_b};
  assign prod   = wide_a * wide_b;

  // Stage 2 registers the product; later stages are pure delay.
  generate
    for (genvar k = 2; k <= STAGES; k++) begin : g_stage
      if (k == 2) begin : g_product
        mul_stage_reg #(.W(2*N)) u_reg (
          .clk       (clk),
          .reset     (reset),
          .advance   (advance),
          .in_valid  (v[1]),
          .in_data   (prod),
          .out_valid (v[2]),
          .out_data  (d[2])
        );
      end else begin : g_delay
        mul_stage_reg #(.W(2*N)) u_reg (
          .clk       (clk),
          .reset     (reset),
          .advance   (advance),
          .in_valid  (v[k-1]),
          .in_data   (d[k-1]),
          .out_valid (v[k]),
          .out_data  (d[k])
        );
      end
    end
  endgenerate

endmodule
`default_nettype wire
